// File: rtl/parity_engine_pkg.sv
// Shared parity-mode encodings and RX checker state encoding for the UART parity engine.
// Mode values keep the legacy even/odd meaning so existing TX configuration is unchanged.
package parity_engine_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_SPACE = 2'b10;
  localparam logic [1:0] PAR_MARK  = 2'b11;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'b00,
    RX_ACCUM = 2'b01,
    RX_CHECK = 2'b10
  } rx_state_e;

endpackage

// File: rtl/parity_engine_if.sv
// TX load and RX sampler signals between the UART framing logic (master) and the parity engine (slave).
// No flow control: every strobe is consumed in the cycle it is presented.
interface parity_engine_if #(
  parameter int WIDTH = 8
);

  logic             PAR_EN;
  logic [1:0]       PAR_MODE;
  logic [WIDTH-1:0] P_DATA;
  logic             Data_Valid;
  logic             par_bit;
  logic             S_START;
  logic             S_BIT_VALID;
  logic             S_BIT;
  logic             par_chk_done;
  logic             par_err;
  logic             rx_busy;

  modport master (
    output PAR_EN, PAR_MODE, P_DATA, Data_Valid, S_START, S_BIT_VALID, S_BIT,
    input  par_bit, par_chk_done, par_err, rx_busy
  );

  modport slave (
    input  PAR_EN, PAR_MODE, P_DATA, Data_Valid, S_START, S_BIT_VALID, S_BIT,
    output par_bit, par_chk_done, par_err, rx_busy
  );

endinterface

// File: rtl/parity_engine_func.sv
// Combinational parity function shared by TX generation and RX checking.
// Zero latency; a disabled parity always yields 0.
module parity_func
  import parity_engine_pkg::*;
(
  input  logic [1:0] mode_i,
  input  logic       xor_i,
  input  logic       en_i,
  output logic       par_o
);

  always_comb begin
    par_o = 1'b0;
    if (en_i) begin
      case (mode_i)
        PAR_EVEN:  par_o = xor_i;
        PAR_ODD:   par_o = ~xor_i;
        PAR_SPACE: par_o = 1'b0;
        PAR_MARK:  par_o = 1'b1;
        default:   par_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/parity_engine.sv
// UART parity engine: TX parity registered one cycle after Data_Valid; RX bit-serial check with
// result one cycle after the final sampled bit. No backpressure; S_START always restarts RX.
module parity_engine
  import parity_engine_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  parity_engine_if.slave bus
);

  logic             tx_par;
  logic             par_bit_q;

  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             acc_q;
  logic             acc_d;
  logic             en_q;
  logic [1:0]       mode_q;
  logic             err_q;
  logic             done_q;
  logic             busy_q;
  logic             rx_exp;
  logic             last_bit;

  parity_func u_tx_func (
    .mode_i (bus.PAR_MODE),
    .xor_i  (^bus.P_DATA),
    .en_i   (bus.PAR_EN),
    .par_o  (tx_par)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_bit_q <= 1'b0;
    end else if (bus.Data_Valid) begin
      par_bit_q <= tx_par;
    end
  end

  // CHECK is only reachable with en_q set, so the RX function is always enabled.
  parity_func u_rx_func (
    .mode_i (mode_q),
    .xor_i  (acc_q),
    .en_i   (1'b1),
    .par_o  (rx_exp)
  );

  assign acc_d    = acc_q ^ bus.S_BIT;
  assign cnt_d    = cnt_q + 1'b1;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      en_q    <= 1'b0;
      mode_q  <= PAR_EVEN;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A start strobe wins over everything, including a same-cycle sampled bit.
      if (bus.S_START) begin
        state_q <= RX_ACCUM;
        cnt_q   <= '0;
        acc_q   <= 1'b0;
        en_q    <= bus.PAR_EN;
        mode_q  <= bus.PAR_MODE;
        err_q   <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          RX_ACCUM: begin
            if (bus.S_BIT_VALID) begin
              acc_q <= acc_d;
              cnt_q <= cnt_d;
              if (last_bit) begin
                if (en_q) begin
                  state_q <= RX_CHECK;
                end else begin
                  state_q <= RX_IDLE;
                  done_q  <= 1'b1;
                  err_q   <= 1'b0;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
          RX_CHECK: begin
            if (bus.S_BIT_VALID) begin
              err_q   <= (bus.S_BIT != rx_exp);
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= RX_IDLE;
            end
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end

  assign bus.par_bit      = par_bit_q;
  assign bus.par_chk_done = done_q;
  assign bus.par_err      = err_q;
  assign bus.rx_busy      = busy_q;

endmodule

// File: tb/tb_parity_engine.sv
// Self-checking bench for parity_engine: directed scenarios plus randomized TX/RX traffic
// against a count-of-ones parity reference, on an 8-bit and a 5-bit instance.
module tb_parity_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int compared = 0;
  int mismatched = 0;

  int   done8_cnt = 0;
  int   done5_cnt = 0;
  logic done8_prev = 1'b0;
  logic done5_prev = 1'b0;

  parity_engine_if #(.WIDTH(8)) if8 ();
  parity_engine_if #(.WIDTH(5)) if5 ();

  parity_engine #(.WIDTH(8)) dut8 (.CLK(clk), .RST(rst), .bus(if8));
  parity_engine #(.WIDTH(5)) dut5 (.CLK(clk), .RST(rst), .bus(if5));

  always #5 clk = ~clk;

  // Reference parity from the mode rules and a count of ones.
  function automatic logic ref_par(input logic [1:0] mode, input int ones, input logic en);
    if (!en) return 1'b0;
    case (mode)
      2'b00:   return logic'(ones % 2);
      2'b01:   return logic'(1 - (ones % 2));
      2'b10:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (if8.par_chk_done === 1'b1) begin
      done8_cnt++;
      compared++;
      if (done8_prev === 1'b1) begin
        mismatched++;
        $display("FAIL done8_consecutive: got two high cycles, want single pulse");
      end
    end
    if (if5.par_chk_done === 1'b1) begin
      done5_cnt++;
      compared++;
      if (done5_prev === 1'b1) begin
        mismatched++;
        $display("FAIL done5_consecutive: got two high cycles, want single pulse");
      end
    end
    done8_prev = if8.par_chk_done;
    done5_prev = if5.par_chk_done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bit8(input logic b);
    if8.S_BIT_VALID = 1'b1;
    if8.S_BIT = b;
    step();
    if8.S_BIT_VALID = 1'b0;
  endtask

  task automatic bit5(input logic b);
    if5.S_BIT_VALID = 1'b1;
    if5.S_BIT = b;
    step();
    if5.S_BIT_VALID = 1'b0;
  endtask

  task automatic test_reset();
    if8.PAR_EN = 0; if8.PAR_MODE = 0; if8.P_DATA = 0; if8.Data_Valid = 0;
    if8.S_START = 0; if8.S_BIT_VALID = 0; if8.S_BIT = 0;
    if5.PAR_EN = 0; if5.PAR_MODE = 0; if5.P_DATA = 0; if5.Data_Valid = 0;
    if5.S_START = 0; if5.S_BIT_VALID = 0; if5.S_BIT = 0;
    #1 rst = 1'b1;
    #2;
    compared++;
    if ({if8.par_bit, if8.par_chk_done, if8.par_err, if8.rx_busy} !== 4'b0) begin
      mismatched++;
      $display("FAIL reset_async8: got %b want 0000",
               {if8.par_bit, if8.par_chk_done, if8.par_err, if8.rx_busy});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    compared++;
    if ({if5.par_bit, if5.par_chk_done, if5.par_err, if5.rx_busy} !== 4'b0) begin
      mismatched++;
      $display("FAIL reset_idle5: got %b want 0000",
               {if5.par_bit, if5.par_chk_done, if5.par_err, if5.rx_busy});
    end
  endtask

  task automatic tx8(input logic [7:0] d, input logic en, input logic [1:0] m,
                     input logic exp, input string nm);
    if8.P_DATA = d; if8.PAR_EN = en; if8.PAR_MODE = m; if8.Data_Valid = 1'b1;
    step();
    if8.Data_Valid = 1'b0;
    compared++;
    if (if8.par_bit !== exp) begin
      mismatched++;
      $display("FAIL %s: got par_bit=%b want %b", nm, if8.par_bit, exp);
    end
  endtask

  task automatic test_tx_directed();
    tx8(8'hA7, 1, 2'b00, 1'b1, "tx_even_A7");
    tx8(8'hA7, 1, 2'b01, 1'b0, "tx_odd_A7");
    tx8(8'h00, 1, 2'b11, 1'b1, "tx_mark_00");
    tx8(8'h00, 1, 2'b10, 1'b0, "tx_space_00");
    tx8(8'h00, 1, 2'b11, 1'b1, "tx_mark_again");
    if8.P_DATA = 8'h01; if8.PAR_MODE = 2'b10; if8.PAR_EN = 0;
    repeat (3) step();
    compared++;
    if (if8.par_bit !== 1'b1) begin
      mismatched++;
      $display("FAIL tx_hold: got par_bit=%b want 1", if8.par_bit);
    end
    tx8(8'h00, 0, 2'b11, 1'b0, "tx_disabled_mark");
  endtask

  task automatic test_tx_random();
    logic       exp_q = 1'b0;
    logic [7:0] d;
    logic       en;
    logic [1:0] m;
    logic       dv;
    for (int n = 0; n < 60; n++) begin
      d = 8'($urandom); en = 1'($urandom); m = 2'($urandom);
      dv = (n == 0) || ($urandom_range(0, 2) != 0);
      if8.P_DATA = d; if8.PAR_EN = en; if8.PAR_MODE = m; if8.Data_Valid = dv;
      step();
      if8.Data_Valid = 1'b0;
      if (dv) exp_q = ref_par(m, $countones(d), en);
      compared++;
      if (if8.par_bit !== exp_q) begin
        mismatched++;
        $display("FAIL tx_random[%0d]: got par_bit=%b want %b", n, if8.par_bit, exp_q);
      end
    end
  endtask

  // One full RX frame on the 8-bit instance, with a concurrent TX load at S_START.
  task automatic rx8_frame(input logic [7:0] d, input logic en, input logic [1:0] mode,
                           input logic pb, input bit scramble, input string nm);
    int         base;
    logic       exp_err;
    logic [7:0] txd;
    txd = 8'($urandom);
    if8.S_START = 1'b1; if8.PAR_EN = en; if8.PAR_MODE = mode;
    if8.P_DATA = txd; if8.Data_Valid = 1'b1;
    step();
    if8.S_START = 1'b0; if8.Data_Valid = 1'b0;
    base = done8_cnt;
    compared++;
    if (if8.rx_busy !== 1'b1 || if8.par_err !== 1'b0 ||
        if8.par_bit !== ref_par(mode, $countones(txd), en)) begin
      mismatched++;
      $display("FAIL %s_start: got busy=%b err=%b par_bit=%b want 1 0 %b", nm,
               if8.rx_busy, if8.par_err, if8.par_bit, ref_par(mode, $countones(txd), en));
    end
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) begin
        if (scramble) begin if8.PAR_EN = 1'($urandom); if8.PAR_MODE = 2'($urandom); end
        step();
      end
      bit8(d[i]);
    end
    if (en) begin
      repeat ($urandom_range(0, 2)) step();
      bit8(pb);
    end
    exp_err = en ? (pb != ref_par(mode, $countones(d), 1'b1)) : 1'b0;
    compared++;
    if (if8.par_chk_done !== 1'b1 || if8.par_err !== exp_err || if8.rx_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_done: got done=%b err=%b busy=%b want 1 %b 0", nm,
               if8.par_chk_done, if8.par_err, if8.rx_busy, exp_err);
    end
    step();
    compared++;
    if (if8.par_chk_done !== 1'b0 || if8.par_err !== exp_err || done8_cnt - base != 1) begin
      mismatched++;
      $display("FAIL %s_after: got done=%b err=%b pulses=%0d want 0 %b 1", nm,
               if8.par_chk_done, if8.par_err, done8_cnt - base, exp_err);
    end
  endtask

  task automatic test_rx_directed();
    rx8_frame(8'h3C, 1, 2'b00, 1'b0, 0, "rx_even_ok");
    rx8_frame(8'h3C, 1, 2'b00, 1'b1, 0, "rx_even_err");
    repeat (5) step();
    compared++;
    if (if8.par_err !== 1'b1) begin
      mismatched++;
      $display("FAIL rx_err_held: got par_err=%b want 1", if8.par_err);
    end
  endtask

  task automatic test_rx_disabled();
    int base;
    rx8_frame(8'h5A, 0, 2'b01, 1'b0, 1, "rx_noparity");
    base = done8_cnt;
    bit8(1'b1);
    step();
    compared++;
    if (done8_cnt != base || if8.rx_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL rx_idle_ignore: got pulses=%0d busy=%b want 0 0", done8_cnt - base, if8.rx_busy);
    end
  endtask

  task automatic test_abort();
    int base;
    base = done8_cnt;
    if8.S_START = 1'b1; if8.PAR_EN = 1'b1; if8.PAR_MODE = 2'b00;
    step();
    if8.S_START = 1'b0;
    for (int i = 0; i < 4; i++) bit8(1'b1);
    if8.S_START = 1'b1; if8.PAR_MODE = 2'b01; if8.S_BIT_VALID = 1'b1; if8.S_BIT = 1'b1;
    step();
    if8.S_START = 1'b0; if8.S_BIT_VALID = 1'b0;
    for (int i = 0; i < 8; i++) bit8(1'b1);
    compared++;
    if (if8.par_chk_done !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_early_done: got done=%b want 0 before parity bit", if8.par_chk_done);
    end
    bit8(1'b1);
    compared++;
    if (if8.par_chk_done !== 1'b1 || if8.par_err !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_result: got done=%b err=%b want 1 0", if8.par_chk_done, if8.par_err);
    end
    step();
    compared++;
    if (done8_cnt - base != 1) begin
      mismatched++;
      $display("FAIL abort_pulses: got %0d want 1", done8_cnt - base);
    end
  endtask

  task automatic test_rx_random();
    for (int n = 0; n < 25; n++) begin
      rx8_frame(8'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1, "rx_random");
      repeat ($urandom_range(0, 1)) step();
    end
  endtask

  task automatic test_width5_and_reset();
    logic [4:0] d;
    int         base;
    d = 5'b10110;
    base = done5_cnt;
    if5.S_START = 1'b1; if5.PAR_EN = 1'b1; if5.PAR_MODE = 2'b01;
    step();
    if5.S_START = 1'b0;
    for (int i = 0; i < 5; i++) bit5(d[i]);
    bit5(1'b0);
    compared++;
    if (if5.par_chk_done !== 1'b1 || if5.par_err !== ref_par(2'b01, $countones(d), 1'b1) ^ 1'b0) begin
      mismatched++;
      $display("FAIL w5_odd: got done=%b err=%b want 1 0", if5.par_chk_done, if5.par_err);
    end
    step();
    compared++;
    if (done5_cnt - base != 1) begin
      mismatched++;
      $display("FAIL w5_pulses: got %0d want 1", done5_cnt - base);
    end
    tx8(8'h01, 1, 2'b00, 1'b1, "tx_pre_reset");
    base = done5_cnt;
    if5.S_START = 1'b1;
    step();
    if5.S_START = 1'b0;
    bit5(1'b1);
    bit5(1'b0);
    #3 rst = 1'b1;
    #1;
    compared++;
    if (if5.rx_busy !== 1'b0 || if5.par_chk_done !== 1'b0 || if5.par_err !== 1'b0 ||
        if8.par_bit !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_midframe: got busy=%b done=%b err=%b par_bit=%b want 0 0 0 0",
               if5.rx_busy, if5.par_chk_done, if5.par_err, if8.par_bit);
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) bit5(1'b1);
    step();
    compared++;
    if (done5_cnt != base || if5.rx_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_no_done: got pulses=%0d busy=%b want 0 0", done5_cnt - base, if5.rx_busy);
    end
  endtask

  initial begin
    test_reset();
    test_tx_directed();
    test_tx_random();
    test_rx_directed();
    test_rx_disabled();
    test_abort();
    test_rx_random();
    test_width5_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/parity_engine.md
Name: parity_engine

Overview:
Parametrised parity unit for the UART. It replaces the TX-only even/odd parity calculator with one block that serves both directions.
- TX side: parallel parity generation with registered configuration.
- RX side: bit-serial parity accumulation and checking, driven by the RX sampler.
- Sits between the TX serializer/FSM and the RX deserializer/FSM.

Parameters:
- WIDTH, 8, data bits per frame; legal range 5..9.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, never overridden.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous active-high reset
- PAR_EN  in  1  parity enabled; sampled with Data_Valid (TX) and S_START (RX)
- PAR_MODE  in  2  00 even, 01 odd, 10 space (always 0), 11 mark (always 1)
- P_DATA  in  WIDTH  TX parallel data
- Data_Valid  in  1  TX load strobe for P_DATA
- par_bit  out  1  TX parity bit for the serializer
- S_START  in  1  RX start-of-frame strobe
- S_BIT_VALID  in  1  RX sampled-bit strobe
- S_BIT  in  1  RX sampled bit value
- par_chk_done  out  1  one-cycle pulse: RX frame parity result valid
- par_err  out  1  RX parity error; held until next S_START
- rx_busy  out  1  RX accumulator between S_START and par_chk_done

Behaviour:
- Reset (async, RST=1): par_bit=0, par_err=0, par_chk_done=0, rx_busy=0; RX FSM to IDLE; accumulator and counter cleared.
- TX path:
  - Data_Valid=1 → next edge par_bit = f(PAR_MODE, ^P_DATA).
  - f: even → ^P_DATA; odd → ~^P_DATA; space → 0; mark → 1.
  - PAR_EN=0 at Data_Valid → par_bit=0.
  - Latency is 1 cycle; par_bit holds until the next Data_Valid.
  - PAR_MODE and P_DATA changes without Data_Valid have no effect.
- RX latched config: PAR_EN and PAR_MODE are captured at S_START into en_q and mode_q and held for the whole frame.
- RX FSM states IDLE, ACCUM, CHECK:
  - IDLE: S_START → ACCUM; acc=0, cnt=0, par_err=0, rx_busy=1.
  - ACCUM, on S_BIT_VALID: acc ^= S_BIT, cnt++.
    - On the valid at cnt==WIDTH-1 with en_q=1 → CHECK.
    - Same condition with en_q=0 → IDLE; par_chk_done pulses, par_err=0, rx_busy=0.
  - CHECK, on S_BIT_VALID: exp = f(mode_q, acc); par_err <= (S_BIT != exp).
    - par_chk_done pulses for 1 cycle in the same edge; rx_busy=0; → IDLE.
- Timing:
  - par_chk_done and par_err are registered and appear the cycle after the final S_BIT_VALID.
  - With no S_BIT_VALID the FSM holds its state indefinitely; there is no timeout.
- S_START in ACCUM or CHECK aborts the frame:
  - restarts as from IDLE (acc/cnt cleared, par_err cleared, config re-latched);
  - no par_chk_done for the aborted frame.
  - S_START and S_BIT_VALID in the same cycle: S_START wins and the bit is discarded.
- S_BIT_VALID in IDLE is ignored.
- TX and RX paths are independent; simultaneous Data_Valid and RX activity is legal.
- par_chk_done is never high for two consecutive cycles.
- RST asserted mid-frame → immediate return to reset values; no done pulse.

Decomposition:
- Shared package / CONFIG_MACROS_Tx.v gains:
  - mode encodings PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_SPACE=2'b10, PAR_MARK=2'b11 (EVEN/ODD keep existing config meaning);
  - RX FSM state encodings (2-bit).
- One sub-module, parity_func: combinational f(mode, xor_in, en) → bit. It is instantiated twice (TX and RX check) so both paths share identical mode semantics.

Test Plan:
1. WIDTH=8, PAR_EN=1, mode even, P_DATA=8'hA7 (5 ones), Data_Valid 1 cycle → par_bit=1 next edge; mode odd, same data → par_bit=0.
2. TX mark/space: P_DATA=8'h00, mode 11 → par_bit=1; mode 10 → par_bit=0; PAR_EN=0, mode 11 → par_bit=0.
3. RX even, S_START, then bits of 8'h3C LSB-first (4 ones), then parity bit 0 → par_chk_done pulse 1 cycle, par_err=0. Repeat with parity bit 1 → par_err=1, held until next S_START.
4. RX with PAR_EN=0 at S_START, PAR_EN toggled mid-frame, 8 bits → par_chk_done after 8th bit, par_err=0, no CHECK state entered.
5. Abort: S_START, 4 bits, S_START with concurrent S_BIT_VALID, then full odd frame 8'hFF with parity 1 → exactly one par_chk_done, par_err=0.
6. WIDTH=5 build, mode odd, bits 5'b10110 then parity 0 → par_err=0. RST pulsed mid-ACCUM → outputs zero asynchronously, rx_busy=0, no done pulse.
